// File: rtl/ps2_defs.sv
// ps2_defs: shared PS/2 state encodings, command/response codes and frame builder
package ps2_defs;
  typedef enum logic [2:0] {IDLE, INHIBIT, SHIFT, ACK, WAIT_IDLE, ERROR} ps2_state_e;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  // Bit 0 goes out first: start(0), data LSB first, odd parity, stop(1)
  function automatic logic [10:0] ps2_frame(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction
endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake plus PS/2 open-drain line sense/drive signals
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic tx_done;
  logic tx_error;
  logic ps2_clk_in;
  logic ps2_dat_in;
  logic ps2_clk_oe;
  logic ps2_dat_oe;
  modport master (
    output tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
    input tx_ready, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe
  );
  modport slave (
    input tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
    output tx_ready, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe
  );
endinterface

// File: rtl/ps2_edge_sync.sv
// ps2_edge_sync: SYNC_STAGES-deep synchronizer with falling-edge detect on the synced line
module ps2_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end
  // Idle PS/2 lines float high, so reset to 1 to avoid a false edge
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end
  assign dout = sync_q[SYNC_STAGES-1];
  assign fall = prev_q & ~dout;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (request-to-send, shift, ACK check).
// Define PS2_TX_RETRY_EN to retry a NACKed or timed-out byte once before flagging tx_error.
module ps2_host_tx
  import ps2_defs::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int SYNC_STAGES = 2
) (
  input logic clock,
  input logic reset,
  ps2_host_tx_if.slave bus
);
  localparam int CNT_MAX = TIMEOUT_CYCLES > INHIBIT_CYCLES ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] INH_START = CW'(INHIBIT_CYCLES - INHIBIT_CYCLES / 10);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT_CYCLES);
  ps2_state_e state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [10:0] sh_q, sh_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d;
  logic clk_s, clk_fall, dat_s, dat_fall_unused, fail;
`ifdef PS2_TX_RETRY_EN
  logic retry_q, retry_d;
`endif
  ps2_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clock(clock), .reset(reset), .din(bus.ps2_clk_in), .dout(clk_s), .fall(clk_fall)
  );
  ps2_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dat_sync (
    .clock(clock), .reset(reset), .din(bus.ps2_dat_in), .dout(dat_s), .fall(dat_fall_unused)
  );
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    sh_d = sh_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d = cnt_q == TMO_MAX ? cnt_q : cnt_q + CW'(1);
    done_d = 1'b0;
    fail = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      IDLE: if (bus.tx_valid) begin
        state_d = INHIBIT;
        data_d = bus.tx_data;
        bit_cnt_d = '0;
        cnt_d = '0;
`ifdef PS2_TX_RETRY_EN
        retry_d = 1'b0;
`endif
      end
      INHIBIT: if (cnt_q == INH_LAST) begin
        state_d = SHIFT;
        sh_d = ps2_frame(data_q);
        bit_cnt_d = '0;
        cnt_d = '0;
      end
      SHIFT: if (clk_fall) begin
        sh_d = {1'b1, sh_q[10:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
        state_d = bit_cnt_q == 4'd9 ? ACK : SHIFT;
      end
      ACK: if (clk_fall) begin
        fail = dat_s;
        state_d = dat_s ? ACK : WAIT_IDLE;
      end
      WAIT_IDLE: if (clk_s && dat_s) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Clock-release-to-ACK watchdog covers the whole device-clocked phase
    if ((state_q == SHIFT || state_q == ACK || state_q == WAIT_IDLE) && cnt_q == TMO_LAST) fail = 1'b1;
    if (fail) begin
`ifdef PS2_TX_RETRY_EN
      state_d = retry_q ? ERROR : INHIBIT;
      retry_d = 1'b1;
      cnt_d = '0;
`else
      state_d = ERROR;
`endif
      done_d = 1'b0;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      data_q <= '0;
      sh_q <= '1;
      bit_cnt_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      sh_q <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
`ifdef PS2_TX_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end
  always_comb begin
    bus.tx_ready = state_q == IDLE && !reset;
    bus.tx_done = done_q;
    bus.tx_error = state_q == ERROR;
    bus.ps2_clk_oe = state_q == INHIBIT;
    bus.ps2_dat_oe = state_q == INHIBIT ? cnt_q >= INH_START : state_q == SHIFT && !sh_q[0];
  end
endmodule
